// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage: main register plus one skid entry, flush-to-bubble, registered In_Ready.
// Optional occupancy statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W     = 96,
   parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}},
   parameter int unsigned       CNT_W      = 16
) (
   input  logic              Clk_40,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Data,
   output logic [CNT_W-1:0]  Stall_Cnt,
   output logic [CNT_W-1:0]  Bubble_Cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;

   // State and payload registers; reset takes priority over flush.
   always_ff @(posedge Clk_40) begin
      if (!Rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= RESET_DATA;
         skid_q      <= RESET_DATA;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state and payload steering; In_Ready/Out_Valid are decoded from the next state.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (Flush) begin
         state_d = ST_EMPTY;
         main_d  = RESET_DATA;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (In_Valid) begin
                  state_d = ST_FULL;
                  main_d  = In_Data;
               end
            end
            ST_FULL: begin
               if (In_Valid && Out_Ready) begin
                  main_d = In_Data;
               end else if (In_Valid) begin
                  state_d = ST_SKID;
                  skid_d  = In_Data;
               end else if (Out_Ready) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (Out_Ready) begin
                  state_d = ST_FULL;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_SKID);
   end

   assign In_Ready  = in_ready_q;
   assign Out_Valid = out_valid_q;
   assign Out_Data  = main_q;

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating counters; flush freezes them, only reset clears them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (!Flush) begin
         if (out_valid_q && !Out_Ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk_40) begin
      if (!Rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign Stall_Cnt  = stall_cnt_q;
   assign Bubble_Cnt = bubble_cnt_q;
`else
   assign Stall_Cnt  = '0;
   assign Bubble_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a 2-deep queue model.
module tb_pipe_stage_reg;
   localparam int unsigned DATA_W = 96;
   localparam int unsigned CNT_W  = 4;
   localparam int          CMAX   = (1 << CNT_W) - 1;

   logic              Clk_40 = 1'b0;
   logic              Rst, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
   logic [DATA_W-1:0] In_Data, Out_Data;
   logic [CNT_W-1:0]  Stall_Cnt, Bubble_Cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference: the stage behaves as a FIFO of at most two entries.
   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] m_data;
   int                m_stall, m_bubble;

   always #5 Clk_40 = ~Clk_40;

   pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .Clk_40    (Clk_40),
      .Rst       (Rst),
      .Flush     (Flush),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .In_Data   (In_Data),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out_Data  (Out_Data),
      .Stall_Cnt (Stall_Cnt),
      .Bubble_Cnt(Bubble_Cnt)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int es, eb;
`ifdef PIPE_STAGE_STATS_EN
      es = m_stall;
      eb = m_bubble;
`else
      es = 0;
      eb = 0;
`endif
      check({tag, ".out_valid"}, 128'(Out_Valid), 128'(mq.size() > 0));
      check({tag, ".in_ready"},  128'(In_Ready),  128'(mq.size() < 2));
      check({tag, ".out_data"},  128'(Out_Data),  128'(m_data));
      check({tag, ".stall_cnt"}, 128'(Stall_Cnt), 128'(es));
      check({tag, ".bubble_cnt"},128'(Bubble_Cnt),128'(eb));
   endtask

   // Apply one cycle of inputs, advance the model at the edge, compare on the falling edge.
   task automatic cyc(input string tag, input logic r, input logic f, input logic iv,
                      input logic [DATA_W-1:0] d, input logic ordy);
      logic acc, tk;
      Rst = r; Flush = f; In_Valid = iv; In_Data = d; Out_Ready = ordy;
      @(posedge Clk_40);
      if (!r) begin
         mq.delete(); m_data = '0; m_stall = 0; m_bubble = 0;
      end else begin
         if (!f) begin
            if (mq.size() > 0 && !ordy && m_stall < CMAX) m_stall++;
            if (mq.size() == 0 && m_bubble < CMAX) m_bubble++;
         end
         if (f) begin
            mq.delete(); m_data = '0;
         end else begin
            acc = iv && (mq.size() < 2);
            tk  = (mq.size() > 0) && ordy;
            if (tk) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (mq.size() > 0) m_data = mq[0];
         end
      end
      @(negedge Clk_40);
      check_all(tag);
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      Rst = 1'b0; Flush = 1'b0; In_Valid = 1'b1; In_Data = '1; Out_Ready = 1'b0;
      m_data = '0; m_stall = 0; m_bubble = 0;
      @(negedge Clk_40);

      // Reset with In_Valid high
      cyc("rst0", 1'b0, 1'b0, 1'b1, '1, 1'b0);
      cyc("rst1", 1'b0, 1'b0, 1'b1, '1, 1'b0);
      check("rst_out_valid", 128'(Out_Valid), 128'(0));
      check("rst_out_data",  128'(Out_Data),  128'(0));
      check("rst_in_ready",  128'(In_Ready),  128'(1));

      // Streaming at full rate
      cyc("str1", 1'b1, 1'b0, 1'b1, 96'h1, 1'b1);
      check("str_d1", 128'(Out_Data), 128'h1);
      cyc("str2", 1'b1, 1'b0, 1'b1, 96'h2, 1'b1);
      check("str_d2", 128'(Out_Data), 128'h2);
      cyc("str3", 1'b1, 1'b0, 1'b1, 96'h3, 1'b1);
      check("str_d3", 128'(Out_Data), 128'h3);
      check("str_ready", 128'(In_Ready), 128'(1));
      cyc("str_drain", 1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("str_hold_after_drain", 128'(Out_Data), 128'h3);

      // Back-pressure: A then B with Out_Ready low
      cyc("bpA", 1'b1, 1'b0, 1'b1, 96'hA, 1'b0);
      cyc("bpB", 1'b1, 1'b0, 1'b1, 96'hB, 1'b0);
      check("bp_ready_low", 128'(In_Ready), 128'(0));
      for (int i = 0; i < 3; i++) begin
         cyc("bp_hold", 1'b1, 1'b0, 1'b1, 96'hE, 1'b0);
         check("bp_data_A", 128'(Out_Data), 128'hA);
      end
      cyc("bp_rel1", 1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("bp_out_B", 128'(Out_Data), 128'hB);
      cyc("bp_rel2", 1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("bp_empty", 128'(Out_Valid), 128'(0));

      // Flush while in SKID
      cyc("flA", 1'b1, 1'b0, 1'b1, 96'hA, 1'b0);
      cyc("flB", 1'b1, 1'b0, 1'b1, 96'hB, 1'b0);
      cyc("flush", 1'b1, 1'b1, 1'b1, 96'hC, 1'b0);
      check("fl_valid", 128'(Out_Valid), 128'(0));
      check("fl_data",  128'(Out_Data),  128'(0));
      check("fl_ready", 128'(In_Ready),  128'(1));
      cyc("fl_after", 1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("fl_noC", 128'(Out_Valid), 128'(0));

      // Reset while stalled in SKID
      cyc("rsA", 1'b1, 1'b0, 1'b1, 96'hA, 1'b0);
      cyc("rsB", 1'b1, 1'b0, 1'b1, 96'hB, 1'b0);
      cyc("rs_hold", 1'b1, 1'b0, 1'b0, '0, 1'b0);
      cyc("rs_rst", 1'b0, 1'b1, 1'b1, 96'hD, 1'b0);
      check("rs_valid", 128'(Out_Valid), 128'(0));
      check("rs_stall", 128'(Stall_Cnt), 128'(0));

      // Idle long enough to saturate the bubble counter
      for (int i = 0; i < 20; i++) cyc("idle", 1'b1, 1'b0, 1'b0, '0, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
      check("sat_bubble", 128'(Bubble_Cnt), 128'(15));
`else
      check("sat_bubble", 128'(Bubble_Cnt), 128'(0));
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rd = {$urandom, $urandom, $urandom};
         cyc("rnd", ($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0),
             1'($urandom_range(0, 1)), rd, ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
